// File: rtl/dls_mon_pkg.sv
// Shared constants and types for the dual-lockstep mismatch monitor.
package dls_mon_pkg;

  localparam logic [1:0] ADDR_STATUS = 2'd0;
  localparam logic [1:0] ADDR_COUNT  = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_THRESH = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    FAULT = 2'd2
  } state_t;

  // CTRL = {irq_en, enable}
  localparam logic [1:0]  CTRL_RST   = 2'b11;
  localparam int unsigned THRESH_RST = 4;

endpackage

// File: rtl/dls_persist_filter.sv
// Persistence filter: edge detector, run counter and IDLE/PEND/FAULT FSM.
module dls_persist_filter
  import dls_mon_pkg::*;
#(
  parameter int unsigned THR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             err,
  input  logic             enable,
  input  logic [THR_W-1:0] thresh,
  input  logic             clear,
  output state_t           state,
  output logic             event_pulse
);

  logic             err_q;
  logic [THR_W-1:0] run;
  logic [THR_W-1:0] run_nxt;
  logic [THR_W-1:0] thr_eff;
  logic [THR_W:0]   run_inc;
  state_t           state_nxt;

  // A threshold of zero is treated as one
  assign thr_eff     = (thresh == '0) ? THR_W'(1) : thresh;
  assign run_inc     = {1'b0, run} + (THR_W+1)'(1);
  assign event_pulse = err & ~err_q & enable;

  // Error history, FSM state and run counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
      state <= IDLE;
      run   <= '0;
    end else begin
      err_q <= err;
      state <= state_nxt;
      run   <= run_nxt;
    end
  end

  // Next state; a software clear overrides any detection in the same cycle
  always_comb begin
    state_nxt = state;
    run_nxt   = run;
    if (clear) begin
      state_nxt = IDLE;
      run_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (err && enable) begin
            run_nxt   = THR_W'(1);
            state_nxt = (thr_eff == THR_W'(1)) ? FAULT : PEND;
          end
        end
        PEND: begin
          if (!err || !enable) begin
            state_nxt = IDLE;
            run_nxt   = '0;
          end else begin
            run_nxt = run_inc[THR_W-1:0];
            if (run_inc >= {1'b0, thr_eff}) state_nxt = FAULT;
          end
        end
        FAULT: state_nxt = FAULT;
        default: begin
          state_nxt = IDLE;
          run_nxt   = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/ahb_dls_monitor.sv
// AHB-Lite register front end for the lockstep mismatch monitor.
module ahb_dls_monitor
  import dls_mon_pkg::*;
#(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned THR_W   = 8,
  parameter int unsigned THR_RST = THRESH_RST
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic        HREADY,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  input  logic        DLS_ERROR,
  output logic        FAULT,
  output logic        IRQ
);

  logic             act_q;
  logic             wr_q;
  logic [1:0]       addr_q;
  logic             wr_en;
  logic             clear;
  logic [1:0]       ctrl;
  logic [THR_W-1:0] thresh;
  logic [CNT_W-1:0] count;
  logic             event_pulse;
  logic             fault;
  state_t           state;
  logic             unused_bits;

  assign unused_bits = ^{HADDR[31:4], HADDR[1:0], HTRANS[0], HWDATA[31:THR_W]};

  assign HREADYOUT = 1'b1;
  assign wr_en     = act_q & wr_q & HREADY;
  assign clear     = wr_en && (addr_q == ADDR_STATUS) && HWDATA[0];
  assign fault     = (state == dls_mon_pkg::FAULT);
  assign FAULT     = fault;
  assign IRQ       = fault & ctrl[1];

  // Address phase capture
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      act_q  <= 1'b0;
      wr_q   <= 1'b0;
      addr_q <= '0;
    end else if (HREADY) begin
      act_q  <= HSEL & HTRANS[1];
      wr_q   <= HWRITE;
      addr_q <= HADDR[3:2];
    end
  end

  // CTRL and THRESH writes commit at the end of the data phase
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ctrl   <= CTRL_RST;
      thresh <= THR_W'(THR_RST);
    end else if (wr_en) begin
      if (addr_q == ADDR_CTRL)   ctrl   <= HWDATA[1:0];
      if (addr_q == ADDR_THRESH) thresh <= HWDATA[THR_W-1:0];
    end
  end

  // Saturating event counter; a software write clears it ahead of any event
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      count <= '0;
    end else if (wr_en && (addr_q == ADDR_COUNT)) begin
      count <= '0;
    end else if (event_pulse && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

  // Read data from the registered address during a read data phase
  always_comb begin
    HRDATA = '0;
    if (act_q && !wr_q) begin
      case (addr_q)
        ADDR_STATUS: HRDATA[3:0] = {state, DLS_ERROR, fault};
        ADDR_COUNT:  HRDATA      = 32'(count);
        ADDR_CTRL:   HRDATA[1:0] = ctrl;
        ADDR_THRESH: HRDATA      = 32'(thresh);
        default:     HRDATA      = '0;
      endcase
    end
  end

  dls_persist_filter #(
    .THR_W(THR_W)
  ) u_filter (
    .clk         (HCLK),
    .rst_n       (HRESETn),
    .err         (DLS_ERROR),
    .enable      (ctrl[0]),
    .thresh      (thresh),
    .clear       (clear),
    .state       (state),
    .event_pulse (event_pulse)
  );

endmodule
